halfband_decim_mc: RTL and testbench



---
 rtl/halfband_decim_mc.sv | 165 ++++++++++++++++
 tb/tb_halfband_decim_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/halfband_decim_mc.sv
// halfband_decim_mc: multi-channel 2:1 halfband decimator.
// It filters NUM_CH channels in lockstep, driven by one shared input strobe.
//
// Ports:
//   clock      : system clock
//   reset      : synchronous, active-low reset
//   enable     : receive gate; when low the filter flushes and idles
//   strobe_in  : one-clock pulse marking a valid input sample
//   data_in    : channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
//   strobe_out : one-clock pulse marking a valid output sample
//   data_out   : filtered samples, packed the same way as data_in
//   sat_out    : per-channel clip flag, valid with strobe_out
module halfband_decim_mc #(
    parameter int NUM_CH = 2,
    parameter int DATA_WIDTH = 16,
    parameter logic signed [15:0] COEFF_C0 = 16'sd9598,
    parameter logic signed [15:0] COEFF_C1 = -16'sd1406
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         strobe_in,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    output logic                         strobe_out,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            sat_out
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = W + 1;
    localparam int MW = W + 17;
    localparam int AW = W + 19;
    localparam int YW = AW - 15;

    localparam logic signed [AW-1:0] HALF = AW'(16384);
    localparam logic signed [YW-1:0] YMAX = YW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [YW-1:0] YMIN = ~YMAX;

    logic accept;
    logic phase;
    logic v1;
    logic v2;
    logic strobe_r;

    assign accept = enable & strobe_in;
    assign strobe_out = strobe_r;

    // Shared control: the phase decides which accepted samples launch an output.
    // Dropping the gate cancels every launch that is still in the pipeline.
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase    <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            strobe_r <= 1'b0;
        end else if (!enable) begin
            phase    <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            v1       <= accept & phase;
            v2       <= v1;
            strobe_r <= v2;
            if (accept) begin
                phase <= ~phase;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [W-1:0]  xin;
        logic signed [W-1:0]  x [7];
        logic signed [PW-1:0] pa_o;
        logic signed [PW-1:0] pa_i;
        logic signed [PW-1:0] s1_o;
        logic signed [PW-1:0] s1_i;
        logic signed [W-1:0]  s1_c;
        logic signed [MW-1:0] p_o;
        logic signed [MW-1:0] p_i;
        logic signed [AW-1:0] acc_c;
        logic signed [AW-1:0] s2_acc;
        logic signed [AW-1:0] rnd;
        logic signed [YW-1:0] yf;
        logic signed [W-1:0]  y_c;
        logic                 sat_c;
        logic signed [W-1:0]  y_r;
        logic                 sat_r;

        assign xin = $signed(data_in[k*W +: W]);

        // Taps are taken from the line as it will look once xin has been
        // shifted in: new x0 is xin, new x2/x3/x4/x6 are old x1/x2/x3/x5.
        assign pa_o = PW'(xin) + PW'(x[5]);
        assign pa_i = PW'(x[1]) + PW'(x[3]);

        always_ff @(posedge clock) begin
            if (!reset || !enable) begin
                for (int i = 0; i < 7; i++) begin
                    x[i] <= '0;
                end
            end else if (accept) begin
                x[0] <= xin;
                for (int i = 1; i < 7; i++) begin
                    x[i] <= x[i-1];
                end
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                s1_o <= '0;
                s1_i <= '0;
                s1_c <= '0;
            end else if (accept) begin
                s1_o <= pa_o;
                s1_i <= pa_i;
                s1_c <= x[2];
            end
        end

        assign p_o   = MW'(s1_o) * MW'(COEFF_C1);
        assign p_i   = MW'(s1_i) * MW'(COEFF_C0);
        // The centre tap is 0.5, so it reduces to a shift.
        assign acc_c = AW'(p_o) + AW'(p_i) + (AW'(s1_c) <<< 14);

        always_ff @(posedge clock) begin
            if (!reset) begin
                s2_acc <= '0;
            end else if (v1) begin
                s2_acc <= acc_c;
            end
        end

        // Round half up, then clip to the output range.
        assign rnd = s2_acc + HALF;
        assign yf  = YW'(rnd >>> 15);

        always_comb begin
            y_c   = yf[W-1:0];
            sat_c = 1'b0;
            if (yf > YMAX) begin
                y_c   = YMAX[W-1:0];
                sat_c = 1'b1;
            end else if (yf < YMIN) begin
                y_c   = YMIN[W-1:0];
                sat_c = 1'b1;
            end
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                y_r   <= '0;
                sat_r <= 1'b0;
            end else if (enable && v2) begin
                y_r   <= y_c;
                sat_r <= sat_c;
            end
        end

        assign data_out[k*W +: W] = y_r;
        assign sat_out[k]         = sat_r;
    end

endmodule

// File: tb/tb_halfband_decim_mc.sv
// tb_halfband_decim_mc: scoreboard bench for halfband_decim_mc.
// A reference model predicts the outputs, and a monitor checks them.
module tb_halfband_decim_mc;

    localparam int W  = 16;
    localparam int NC = 2;
    localparam longint C0 = 9598;
    localparam longint C1 = -1406;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          strobe_in = 1'b0;
    logic [NC*W-1:0] data_in = '0;
    logic          strobe_out;
    logic [NC*W-1:0] data_out;
    logic [NC-1:0] sat_out;

    halfband_decim_mc #(
        .NUM_CH(NC),
        .DATA_WIDTH(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .strobe_in(strobe_in),
        .data_in(data_in),
        .strobe_out(strobe_out),
        .data_out(data_out),
        .sat_out(sat_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int d0;
        int d1;
        bit s0;
        bit s1;
    } exp_t;

    exp_t sb[$];
    int   hist0[$];
    int   hist1[$];
    int   got0[$];
    bit   gsat0[$];
    bit   ph = 1'b0;
    bit   neg_mode = 1'b0;
    int   cur = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cur);
        end
    endfunction

    // Filter output for a history with the newest sample first.
    // Missing history counts as zero.
    function automatic void filt(input int h[$], output int y, output bit s);
        longint x[7];
        longint acc;
        longint q;
        for (int i = 0; i < 7; i++) begin
            x[i] = (i < h.size()) ? longint'(h[i]) : 0;
        end
        acc = C1 * (x[0] + x[6]) + C0 * (x[2] + x[4]) + 16384 * x[3];
        q = (acc + 16384) >>> 15;
        s = 1'b0;
        if (q > 32767) begin
            y = 32767;
            s = 1'b1;
        end else if (q < -32768) begin
            y = -32768;
            s = 1'b1;
        end else begin
            y = int'(q);
        end
    endfunction

    task automatic step(input bit en, input bit stb, input int a, input int b);
        exp_t e;
        enable    = en;
        strobe_in = stb;
        data_in   = {16'(b), 16'(a)};
        if (!reset) begin
            hist0.delete();
            hist1.delete();
            ph = 1'b0;
        end else if (!en) begin
            hist0.delete();
            hist1.delete();
            ph = 1'b0;
            // Launches from the previous two cycles never reach the output.
            while (sb.size() > 0 && sb[$].cyc >= cur - 2) begin
                void'(sb.pop_back());
            end
        end else if (stb) begin
            hist0.push_front(a);
            hist1.push_front(b);
            if (hist0.size() > 7) void'(hist0.pop_back());
            if (hist1.size() > 7) void'(hist1.pop_back());
            if (ph) begin
                e.cyc = cur;
                filt(hist0, e.d0, e.s0);
                filt(hist1, e.d1, e.s1);
                sb.push_back(e);
            end
            ph = ~ph;
        end
        @(posedge clock);
        #1;
        cur++;
    endtask

    always @(negedge clock) begin
        if (strobe_out) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe_out", 1, 0);
            end else begin
                exp_t e;
                int y0;
                int y1;
                e = sb.pop_front();
                y0 = int'($signed(data_out[15:0]));
                y1 = int'($signed(data_out[31:16]));
                chk("latency", cur, e.cyc + 3);
                chk("ch0_data", y0, e.d0);
                chk("ch1_data", y1, e.d1);
                chk("ch0_sat", int'(sat_out[0]), int'(e.s0));
                chk("ch1_sat", int'(sat_out[1]), int'(e.s1));
                if (neg_mode) chk("ch1_negation", y1, -y0);
                got0.push_back(y0);
                gsat0.push_back(sat_out[0]);
            end
        end
    end

    task automatic flush();
        repeat (3) step(1'b0, 1'b0, 0, 0);
        got0.delete();
        gsat0.delete();
    endtask

    // kind 0: impulse at sample 41, kind 1: impulse at sample 40,
    // kind 2: step starting at sample 41.
    task automatic run_test(input int kind, input int val, input bit gap);
        int a;
        flush();
        for (int i = 0; i < 50; i++) begin
            case (kind)
                0: a = (i == 41) ? val : 0;
                1: a = (i == 40) ? val : 0;
                default: a = (i >= 41) ? val : 0;
            endcase
            step(1'b1, 1'b1, a, 0);
            if (gap && (i % 3 == 0)) step(1'b1, 1'b0, 0, 0);
        end
        repeat (6) step(1'b1, 1'b0, 0, 0);
    endtask

    initial begin
        int e;
        int a;
        bit en;
        bit stb;

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 16384, -16384);
            chk("reset_strobe_out", int'(strobe_out), 0);
            chk("reset_data_out", int'(data_out), 0);
            chk("reset_sat_out", int'(sat_out), 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1234, 4321);
            chk("idle_strobe_out", int'(strobe_out), 0);
        end

        run_test(0, 16384, 1'b1);
        chk("imp_odd_count", got0.size(), 25);
        for (int i = 0; i < 25 && i < got0.size(); i++) begin
            e = (i == 20 || i == 23) ? -703 : (i == 21 || i == 22) ? 4799 : 0;
            chk("imp_odd_value", got0[i], e);
        end

        run_test(1, 16384, 1'b0);
        chk("imp_even_count", got0.size(), 25);
        for (int i = 0; i < 25 && i < got0.size(); i++) begin
            chk("imp_even_value", got0[i], (i == 21) ? 8192 : 0);
        end

        run_test(2, 32767, 1'b1);
        chk("step_max_count", got0.size(), 25);
        if (got0.size() == 25) begin
            chk("step_max_y20", got0[20], -1406);
            chk("step_max_y21", got0[21], 8192);
            chk("step_max_y22", got0[22], 32767);
            chk("step_max_sat22", int'(gsat0[22]), 1);
            chk("step_max_y23", got0[23], 32767);
            chk("step_max_sat23", int'(gsat0[23]), 0);
        end

        run_test(2, 16384, 1'b0);
        chk("step_half_count", got0.size(), 25);
        if (got0.size() == 25) chk("step_half_settled", got0[24], 16384);

        flush();
        repeat (4) step(1'b1, 1'b1, 1000, 1000);
        repeat (4) step(1'b0, 1'b0, 0, 0);
        chk("flush_count", got0.size(), 1);
        got0.delete();
        gsat0.delete();
        repeat (4) step(1'b1, 1'b1, 1000, 1000);
        repeat (6) step(1'b1, 1'b0, 0, 0);
        chk("reenable_count", got0.size(), 2);
        if (got0.size() == 2) begin
            chk("reenable_first", got0[0], -43);
            chk("reenable_second", got0[1], 750);
        end

        flush();
        neg_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(7) == 0) ? 16384 : 0;
            step(1'b1, 1'b1, a, -a);
        end
        repeat (6) step(1'b1, 1'b0, 0, 0);
        neg_mode = 1'b0;
        chk("full_rate_count", got0.size(), 100);

        flush();
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b1, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(65535)) - 32768);
        end
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(15) != 0);
            stb = ($urandom_range(3) != 0);
            step(en, stb, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(65535)) - 32768);
        end
        repeat (6) step(1'b1, 1'b0, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
